pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised program-counter generator at the head of the IF stage; the next generation of the team's PC register.
//  Computes next-PC internally: sequential, redirect, trap vector or stall-hold.
//  Adds a run/halt state machine, prioritised redirects, alignment checking and an optional return-address stack (RAS).
//  Feeds instruction-memory address and IF/ID pipeline register.
// PARAMETERS
//  XLEN       32          PC width in bits
//  INC_BYTES  4           sequential increment; power of two; ALIGN = log2(INC_BYTES)
//  RESET_PC   32'h0       PC value in IDLE and after reset
//  TRAP_VEC   32'h80      target taken on trap_i
//  RAS_DEPTH  4           RAS entries, power of two >= 2 (used only with PC_RAS_EN)
// PORTS
//  clk_i            in   1     clock, rising edge
//  rst_i            in   1     reset: synchronous, active-high
//  start_i          in   1     level; 1 = core enabled, 0 = return to IDLE
//  stall_i          in   1     hazard-detect stall: hold PC
//  halt_i           in   1     enter HALT (e.g. halt instruction retired)
//  redirect_i       in   1     branch/jump taken
//  redirect_pc_i    in   XLEN  branch/jump target
//  trap_i           in   1     exception: jump to TRAP_VEC
//  call_i           in   1     [PC_RAS_EN] current fetch is a call
//  ret_i            in   1     [PC_RAS_EN] current fetch is a return
//  pc_o             out  XLEN  current fetch PC (registered)
//  pc_valid_o       out  1     pc_o is a real fetch (RUN state)
//  misalign_o       out  1     1-cycle pulse: redirect target had nonzero low ALIGN bits
//  ras_underflow_o  out  1     [PC_RAS_EN] 1-cycle pulse: ret_i on an empty RAS
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge) overrides everything: state=IDLE, pc_o=RESET_PC, all flags 0, RAS emptied.
//  - States:
//    - IDLE: pc_o=RESET_PC, valid=0. start_i=1 -> RUN; pc_o stays RESET_PC, valid=1 from the next cycle.
//    - RUN:  valid=1. start_i=0 -> IDLE (pc_o<=RESET_PC). halt_i=1 -> HALT (pc_o held, valid=0).
//    - HALT: valid=0, pc held. trap_i=1 -> RUN at TRAP_VEC. start_i=0 -> IDLE. Other inputs ignored.
//  - Next-PC priority in RUN, highest first; all updates registered, 1-cycle latency:
//    1. start_i=0
//    2. trap_i
//    3. redirect_i
//    4. ret_i (RAS)
//    5. stall_i (hold)
//    6. pc_o + INC_BYTES
//  - Redirect/trap override stall in the same cycle.
//  - Arithmetic is modulo 2^XLEN: the PC wraps from max to 0 with no flag.
//  - Redirect target low ALIGN bits are forced to 0. misalign_o pulses in the cycle after acceptance when they were nonzero.
//  - halt_i together with trap_i or redirect_i: trap/redirect win and halt_i is dropped.
// CONFIGURATION
//  PC_RAS_EN defined: a RAS of RAS_DEPTH entries is built.
//   - call_i (accepted, not stalled) pushes pc_o+INC_BYTES.
//   - ret_i pops; the popped value is the next PC.
//   - Push when full overwrites the oldest entry (circular pointer).
//   - ret_i on empty: sequential next-PC, ras_underflow_o pulses.
//   - call_i & ret_i in the same cycle: pop target used, then return address pushed (top replaced, count unchanged).
//   - Stalled cycles do not push or pop.
//   - trap_i does not alter the RAS.
//  PC_RAS_EN undefined: call_i/ret_i ports present and ignored; ras_underflow_o tied 0; no RAS logic.
// STRUCTURE
//  Package pc_pkg: pc_state_e {IDLE, RUN, HALT}; ALIGN localparam function; default XLEN/RESET_PC/TRAP_VEC constants.
//  Sub-module pc_ras (push/pop/top/empty/full, depth-parametrised), instantiated only under PC_RAS_EN.
// TESTING
//  1. Reset held 2 cycles, then start_i=1 -> pc_o 0x0 valid=1, then 0x4, 0x8, 0xC on consecutive cycles.
//  2. stall_i=1 at pc=0x8 for 3 cycles -> pc_o stays 0x8; redirect_i with 0x40 during stall -> 0x40 next cycle.
//  3. Same cycle trap_i=1 and redirect_i=1 with 0x100 -> pc_o=0x80. redirect_pc_i=0x103 -> pc_o=0x100, misalign_o pulse.
//  4. pc=0xFFFF_FFFC, no stall -> pc_o=0x0. halt_i -> valid=0, pc held. start_i=0 -> pc_o=RESET_PC.
//  5. [PC_RAS_EN] call at 0x10 and 0x20 -> RAS {0x14,0x24}. Two ret_i -> 0x24 then 0x14. Third ret_i -> sequential, underflow pulse.
//  6. rst_i asserted mid-RUN with a pending redirect -> next cycle IDLE, pc_o=RESET_PC, RAS empty.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage PC generator.
package pc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_e;

  localparam int          DEF_XLEN      = 32;
  localparam int          DEF_INC_BYTES = 4;
  localparam int          DEF_RAS_DEPTH = 4;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h80;

  // Number of low PC bits that must be zero for a legal fetch address.
  function automatic int align_of(input int inc_bytes);
    return $clog2(inc_bytes);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// push and pop together replace the top entry (count unchanged).
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr, top_idx;
  logic [AW:0]   cnt;

  assign top_idx = ptr - AW'(1);
  assign top     = mem[top_idx];
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));

  always_ff @(posedge clk_i) begin
    if (push && pop)  mem[top_idx] <= din;
    else if (push)    mem[ptr]     <= din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + AW'(1);
      if (!full) cnt <= cnt + (AW+1)'(1);
    end else if (pop && !push) begin
      ptr <= ptr - AW'(1);
      cnt <= cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator with IDLE/RUN/HALT control and prioritised redirects.
// Define PC_RAS_EN to build the return-address stack for call_i/ret_i.
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter int              INC_BYTES = DEF_INC_BYTES,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic            ras_underflow_o
);
  localparam int              ALIGN    = align_of(INC_BYTES);
  localparam logic [XLEN-1:0] INC      = XLEN'(INC_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = (XLEN'(1) << ALIGN) - XLEN'(1);

  pc_state_e       state;
  logic [XLEN-1:0] pc_seq, tgt, ras_top;
  logic            mis, accept, use_ret, ras_pop, ras_uf;

  assign pc_seq = pc_o + INC;
  assign tgt    = redirect_pc_i & ~LOW_MASK;
  assign mis    = |(redirect_pc_i & LOW_MASK);

  // A fetch "commits" to the RAS only when it actually advances: not trapping,
  // not stalled, and not halting (a redirect cancels a simultaneous halt).
  assign accept  = (state == RUN) && start_i && !trap_i && !stall_i &&
                   (redirect_i || !halt_i);
  assign use_ret = accept && ret_i && !redirect_i;

`ifdef PC_RAS_EN
  logic ras_empty, ras_full_unused;

  assign ras_pop = use_ret && !ras_empty;
  assign ras_uf  = use_ret && ras_empty;

  pc_ras #(.W(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (accept && call_i),
    .pop   (ras_pop),
    .din   (pc_seq),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full_unused)
  );
`else
  logic ras_unused;
  assign ras_unused = ^{call_i, use_ret, RAS_DEPTH};
  assign ras_pop    = 1'b0;
  assign ras_uf     = 1'b0;
  assign ras_top    = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      pc_o            <= RESET_PC;
      pc_valid_o      <= 1'b0;
      misalign_o      <= 1'b0;
      ras_underflow_o <= 1'b0;
    end else begin
      misalign_o      <= 1'b0;
      ras_underflow_o <= ras_uf;
      unique case (state)
        IDLE: begin
          pc_o <= RESET_PC;
          if (start_i) begin
            state      <= RUN;
            pc_valid_o <= 1'b1;
          end
        end
        RUN: begin
          if (!start_i) begin
            state      <= IDLE;
            pc_o       <= RESET_PC;
            pc_valid_o <= 1'b0;
          end else if (trap_i) begin
            pc_o <= TRAP_VEC;
          end else if (redirect_i) begin
            pc_o       <= tgt;
            misalign_o <= mis;
          end else if (halt_i) begin
            state      <= HALT;
            pc_valid_o <= 1'b0;
          end else if (!stall_i) begin
            pc_o <= ras_pop ? ras_top : pc_seq;
          end
        end
        HALT: begin
          if (!start_i) begin
            state <= IDLE;
            pc_o  <= RESET_PC;
          end else if (trap_i) begin
            state      <= RUN;
            pc_o       <= TRAP_VEC;
            pc_valid_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed vector table plus randomized run against a behavioural PC model.
module tb_pc_gen_unit;
  import pc_pkg::*;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, stall, halt, redir, trap, call, ret;
  logic [31:0] rpc;
  logic [31:0] pc_o;
  logic        pc_valid_o, misalign_o, ras_underflow_o;

  always #5 clk = ~clk;

  pc_gen_unit dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .halt_i(halt),
    .redirect_i(redir), .redirect_pc_i(rpc), .trap_i(trap), .call_i(call),
    .ret_i(ret), .pc_o(pc_o), .pc_valid_o(pc_valid_o), .misalign_o(misalign_o),
    .ras_underflow_o(ras_underflow_o)
  );

  typedef struct {
    string       nm;
    logic [5:0]  ctl;   // {rst,start,stall,halt,redir,trap}
    logic [1:0]  cr;    // {call,ret}
    logic [31:0] rpc;
    logic [31:0] pc;
    logic        v, mis, uf;
  } vec_t;

  localparam logic [5:0] R = 6'b100000, S = 6'b010000, ST = 6'b001000,
                         H = 6'b000100, RD = 6'b000010, T = 6'b000001;
  localparam logic [1:0] CL = 2'b10, RT = 2'b01;

  vec_t tbl[$];
  int   checks = 0, passes = 0;

  // Behavioural model state: mode 0=idle 1=run 2=halt
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_mis, m_uf;
  logic [31:0] ras_q[$];

  function automatic vec_t mk(string nm, logic [5:0] ctl, logic [1:0] cr,
                              logic [31:0] r, logic [31:0] pc, logic v, logic m, logic u);
    vec_t x;
    x.nm = nm; x.ctl = ctl; x.cr = cr; x.rpc = r; x.pc = pc; x.v = v; x.mis = m; x.uf = u;
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] pc, logic v, logic m, logic u);
    checks++;
    if (pc_o === pc && pc_valid_o === v && misalign_o === m && ras_underflow_o === u)
      passes++;
    else
      $display("FAIL %s: got pc=%h v=%b mis=%b uf=%b, want pc=%h v=%b mis=%b uf=%b",
               nm, pc_o, pc_valid_o, misalign_o, ras_underflow_o, pc, v, m, u);
  endtask

  task automatic model_step;
    logic [31:0] seq, nxt;
    seq   = m_pc + 32'd4;
    m_mis = 1'b0;
    m_uf  = 1'b0;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; ras_q.delete();
    end else if (m_mode == 0) begin
      m_pc = 32'h0;
      if (start) m_mode = 1;
    end else if (!start) begin
      m_mode = 0; m_pc = 32'h0;
    end else if (m_mode == 2) begin
      if (trap) begin m_mode = 1; m_pc = 32'h80; end
    end else if (trap) begin
      m_pc = 32'h80;
    end else if (redir) begin
      if (RAS_ON && call && !stall) ras_q.push_back(seq);
      m_pc  = rpc & ~32'h3;
      m_mis = (rpc[1:0] != 2'b00);
    end else if (halt) begin
      m_mode = 2;
    end else if (!stall) begin
      nxt = seq;
      if (RAS_ON && ret) begin
        if (ras_q.size() > 0) nxt = ras_q.pop_back();
        else m_uf = 1'b1;
      end
      if (RAS_ON && call) ras_q.push_back(seq);
      m_pc = nxt;
    end
    if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
  endtask

  initial begin
    {rst, start, stall, halt, redir, trap, call, ret} = '0;
    rpc = '0;

    tbl.push_back(mk("rst0",        R,       0,  0,            32'h0,        0, 0, 0));
    tbl.push_back(mk("rst1",        R,       0,  0,            32'h0,        0, 0, 0));
    tbl.push_back(mk("start",       S,       0,  0,            32'h0,        1, 0, 0));
    tbl.push_back(mk("seq4",        S,       0,  0,            32'h4,        1, 0, 0));
    tbl.push_back(mk("seq8",        S,       0,  0,            32'h8,        1, 0, 0));
    tbl.push_back(mk("stall1",      S|ST,    0,  0,            32'h8,        1, 0, 0));
    tbl.push_back(mk("stall2",      S|ST,    0,  0,            32'h8,        1, 0, 0));
    tbl.push_back(mk("stall3",      S|ST,    0,  0,            32'h8,        1, 0, 0));
    tbl.push_back(mk("stall_redir", S|ST|RD, 0,  32'h40,       32'h40,       1, 0, 0));
    tbl.push_back(mk("seq44",       S,       0,  0,            32'h44,       1, 0, 0));
    tbl.push_back(mk("trap_redir",  S|T|RD,  0,  32'h100,      32'h80,       1, 0, 0));
    tbl.push_back(mk("misalign",    S|RD,    0,  32'h103,      32'h100,      1, 1, 0));
    tbl.push_back(mk("mis_clear",   S,       0,  0,            32'h104,      1, 0, 0));
    tbl.push_back(mk("to_max",      S|RD,    0,  32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0));
    tbl.push_back(mk("wrap",        S,       0,  0,            32'h0,        1, 0, 0));
    tbl.push_back(mk("seq_4",       S,       0,  0,            32'h4,        1, 0, 0));
    tbl.push_back(mk("halt",        S|H,     0,  0,            32'h4,        0, 0, 0));
    tbl.push_back(mk("halt_ign",    S|RD|ST, 0,  32'h200,      32'h4,        0, 0, 0));
    tbl.push_back(mk("halt_trap",   S|T,     0,  0,            32'h80,       1, 0, 0));
    tbl.push_back(mk("halt2",       S|H,     0,  0,            32'h80,       0, 0, 0));
    tbl.push_back(mk("halt_idle",   0,       0,  0,            32'h0,        0, 0, 0));
    tbl.push_back(mk("idle_hold",   0,       0,  0,            32'h0,        0, 0, 0));
    tbl.push_back(mk("restart",     S,       0,  0,            32'h0,        1, 0, 0));
    tbl.push_back(mk("seq_4b",      S,       0,  0,            32'h4,        1, 0, 0));
    tbl.push_back(mk("redir_halt",  S|RD|H,  0,  32'h300,      32'h300,      1, 0, 0));
    tbl.push_back(mk("seq304",      S,       0,  0,            32'h304,      1, 0, 0));
    tbl.push_back(mk("rst_mid",     R|S|RD,  0,  32'h500,      32'h0,        0, 0, 0));
    tbl.push_back(mk("post_rst",    S,       0,  0,            32'h0,        1, 0, 0));
    tbl.push_back(mk("post_rst4",   S,       0,  0,            32'h4,        1, 0, 0));
    tbl.push_back(mk("run_idle",    0,       0,  0,            32'h0,        0, 0, 0));
`ifdef PC_RAS_EN
    tbl.push_back(mk("ras_start",   S,       0,  0,            32'h0,        1, 0, 0));
    tbl.push_back(mk("ras_j10",     S|RD,    0,  32'h10,       32'h10,       1, 0, 0));
    tbl.push_back(mk("call10",      S|RD,    CL, 32'h20,       32'h20,       1, 0, 0));
    tbl.push_back(mk("call20",      S|RD,    CL, 32'h50,       32'h50,       1, 0, 0));
    tbl.push_back(mk("ret1",        S,       RT, 0,            32'h24,       1, 0, 0));
    tbl.push_back(mk("ret2",        S,       RT, 0,            32'h14,       1, 0, 0));
    tbl.push_back(mk("ret_uf",      S,       RT, 0,            32'h18,       1, 0, 1));
    tbl.push_back(mk("uf_clr",      S,       0,  0,            32'h1C,       1, 0, 0));
    tbl.push_back(mk("call_pre_rst",S|RD,    CL, 32'h60,       32'h60,       1, 0, 0));
    tbl.push_back(mk("rst_ras",     R,       0,  0,            32'h0,        0, 0, 0));
    tbl.push_back(mk("ras_start2",  S,       0,  0,            32'h0,        1, 0, 0));
    tbl.push_back(mk("ret_post_rst",S,       RT, 0,            32'h4,        1, 0, 1));
`endif

    foreach (tbl[i]) begin
      {rst, start, stall, halt, redir, trap} = tbl[i].ctl;
      {call, ret} = tbl[i].cr;
      rpc = tbl[i].rpc;
      tick();
      chk(tbl[i].nm, tbl[i].pc, tbl[i].v, tbl[i].mis, tbl[i].uf);
    end

    // Randomized run; the first cycle resets both DUT and model.
    for (int n = 0; n < 600; n++) begin
      rst   = (n == 0) || ($urandom_range(0, 99) < 2);
      start = ($urandom_range(0, 99) < 96);
      stall = ($urandom_range(0, 99) < 20);
      halt  = ($urandom_range(0, 99) < 5);
      trap  = ($urandom_range(0, 99) < 5);
      redir = ($urandom_range(0, 99) < 15);
      call  = ($urandom_range(0, 99) < 15);
      ret   = ($urandom_range(0, 99) < 15);
      rpc   = $urandom();
      model_step();
      tick();
      chk($sformatf("rand%0d", n), m_pc, (m_mode == 1), m_mis, m_uf);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
